inst_fetch_unit: RTL and testbench

//  Instruction fetch stage upstream of the control/decode path: owns the PC and issues

---
 rtl/inst_fetch_unit_pkg.sv | 20 ++
 rtl/inst_fetch_unit_fifo.sv | 51 +++++
 rtl/inst_fetch_unit.sv | 140 ++++++++++++++
 tb/tb_inst_fetch_unit.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_unit_pkg.sv
// Shared constants and the fetch entry record for the instruction fetch unit.
// Used by inst_fetch_unit; the optional fault path is enabled by FETCH_FAULT_EN.
package inst_fetch_unit_pkg;

  localparam logic [31:0] INITIAL_PC = 32'h0040_0000;
  localparam logic [31:0] NOP_INST   = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        fault;
  } fetch_entry_t;

  localparam int ENTRY_W = $bits(fetch_entry_t);

  function automatic logic is_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/inst_fetch_unit_fifo.sv
// Synchronous DEPTH-entry FIFO with flush; head is read straight from the register array.
// Used for both the fetched-word queue and the request-PC tag queue.
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head_data,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  // A flush overrides any push or pop issued in the same cycle.
  assign do_pop  = pop && (count != '0) && !flush;
  assign do_push = push && !flush;

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  assign head_data = mem[rd_ptr];

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues pipelined imem reads and buffers words for decode.
// Define FETCH_FAULT_EN to add the imem_err port and misaligned-redirect fault entries.
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = INITIAL_PC,
  parameter int          DEPTH    = 4
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
`ifdef FETCH_FAULT_EN
  input  logic        imem_err,
`endif
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_fault
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]  pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] discard;
  logic [CW-1:0] data_count;
  logic [CW-1:0] tag_count;
  logic [31:0]  tag_head;
  logic         grant;
  logic         keep_resp;
  logic         credit;
  logic         fetch_en;
  logic         fault_push;
  logic         resp_err;
  logic [31:0]  next_redirect_pc;
  fetch_entry_t push_entry;
  fetch_entry_t head_entry;

`ifdef FETCH_FAULT_EN
  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_FAULT = 2'd1;
  localparam logic [1:0] ST_HALT  = 2'd2;
  logic [1:0] state;

  assign fetch_en         = (state == ST_FETCH);
  assign fault_push       = (state == ST_FAULT);
  assign resp_err         = imem_err;
  assign next_redirect_pc = redirect_pc;
`else
  assign fetch_en         = 1'b1;
  assign fault_push       = 1'b0;
  assign resp_err         = 1'b0;
  assign next_redirect_pc = redirect_pc & ~32'h0000_0003;
`endif

  // Words already requested count against FIFO space so a response never finds it full.
  assign credit    = ({1'b0, outstanding} + {1'b0, data_count}) < (CW+1)'(DEPTH);
  assign imem_req  = !reset && !redirect_valid && fetch_en && credit;
  assign imem_addr = pc;
  assign grant     = imem_req && imem_gnt;
  assign keep_resp = imem_rvalid && (discard == '0) && !redirect_valid;

  always_comb begin
    push_entry = '0;
    if (fault_push) begin
      push_entry.pc    = pc;
      push_entry.fault = 1'b1;
    end else begin
      push_entry.inst  = imem_rdata;
      push_entry.pc    = tag_head;
`ifdef FETCH_FAULT_EN
      push_entry.fault = resp_err | is_misaligned(tag_head);
`else
      push_entry.fault = resp_err;
`endif
    end
  end

  fetch_fifo #(.WIDTH(ENTRY_W), .DEPTH(DEPTH)) u_data_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (keep_resp || fault_push),
    .push_data (push_entry),
    .pop       (inst_valid && inst_ready),
    .flush     (redirect_valid),
    .head_data (head_entry),
    .count     (data_count)
  );

  fetch_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_tag_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (grant),
    .push_data (pc),
    .pop       (keep_resp && (tag_count != '0)),
    .flush     (redirect_valid),
    .head_data (tag_head),
    .count     (tag_count)
  );

  // On redirect every request still in flight becomes a word to throw away.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc          <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
`ifdef FETCH_FAULT_EN
      state       <= ST_FETCH;
`endif
    end else begin
      outstanding <= outstanding + CW'(grant) - CW'(imem_rvalid);
      if (redirect_valid) begin
        discard <= outstanding - CW'(imem_rvalid);
        pc      <= next_redirect_pc;
`ifdef FETCH_FAULT_EN
        state   <= is_misaligned(redirect_pc) ? ST_FAULT : ST_FETCH;
`endif
      end else begin
        if (imem_rvalid && (discard != '0)) discard <= discard - CW'(1);
        if (grant) pc <= pc + 32'd4;
`ifdef FETCH_FAULT_EN
        if (state == ST_FAULT) state <= ST_HALT;
`endif
      end
    end
  end

  assign inst_valid = (data_count != '0);
  assign inst       = head_entry.inst;
  assign inst_pc    = head_entry.pc;
  assign inst_fault = head_entry.fault;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit with a fixed-latency in-order memory model.
// Build with FETCH_FAULT_EN defined to exercise the fault path as well.
module tb_inst_fetch_unit;

  localparam logic [31:0] KEY = 32'h5A5A_0000;

  typedef struct {
    logic        ready;
    logic        redir;
    logic [31:0] rpc;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        chk_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        imem_err;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_fault;

  int          checks = 0;
  int          errors = 0;
  int          lat = 1;
  logic        gnt_en = 1'b1;
  logic [31:0] err_addr = 32'hFFFF_FFFF;
  logic        pipe_v [8];
  logic [31:0] pipe_a [8];
  vec_t        vecs [13];

  always #5 clock = ~clock;

  inst_fetch_unit dut (
    .clock          (clock),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
`ifdef FETCH_FAULT_EN
    .imem_err       (imem_err),
`endif
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_fault     (inst_fault)
  );

  // Memory answers each granted address after lat cycles, in order.
  always @(posedge clock) begin
    pipe_v[0] <= imem_req && imem_gnt;
    pipe_a[0] <= imem_addr;
    for (int i = 1; i < 8; i++) begin
      pipe_v[i] <= pipe_v[i-1];
      pipe_a[i] <= pipe_a[i-1];
    end
  end

  assign imem_gnt    = gnt_en;
  assign imem_rvalid = pipe_v[lat-1];
  assign imem_rdata  = pipe_a[lat-1] ^ KEY;
  assign imem_err    = pipe_v[lat-1] && (pipe_a[lat-1] == err_addr);

  function automatic vec_t mkv(input logic rdy, input logic rd, input logic [31:0] rpc,
                               input logic er, input logic [31:0] ea, input logic ca,
                               input logic ev, input logic [31:0] ep);
    vec_t v;
    v.ready = rdy; v.redir = rd; v.rpc = rpc; v.exp_req = er;
    v.exp_addr = ea; v.chk_addr = ca; v.exp_valid = ev; v.exp_pc = ep;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic rdy, input logic rd, input logic [31:0] rpc);
    @(negedge clock);
    reset          = 1'b0;
    inst_ready     = rdy;
    redirect_valid = rd;
    redirect_pc    = rpc;
    #1;
  endtask

  task automatic resetDut();
    @(negedge clock);
    reset = 1'b1; inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    gnt_en = 1'b1; lat = 1; err_addr = 32'hFFFF_FFFF;
    repeat (8) @(posedge clock);
  endtask

  task automatic waitValid(input string name, input int limit, output int cycles);
    cycles = 0;
    applyStimulus(1'b1, 1'b0, '0);
    while (!inst_valid && cycles < limit) begin
      cycles++;
      applyStimulus(1'b1, 1'b0, '0);
    end
    if (!inst_valid) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: inst_valid never rose within %0d cycles, expected 1", name, limit);
    end
  endtask

  initial begin
    int grants;
    int cyc;
    int reqs;

    vecs[0]  = mkv(1, 0, 0,            1, 32'h0040_0000, 1, 0, 0);
    vecs[1]  = mkv(1, 0, 0,            1, 32'h0040_0004, 1, 0, 0);
    vecs[2]  = mkv(1, 0, 0,            1, 32'h0040_0008, 1, 1, 32'h0040_0000);
    vecs[3]  = mkv(1, 0, 0,            1, 32'h0040_000C, 1, 1, 32'h0040_0004);
    vecs[4]  = mkv(1, 0, 0,            1, 32'h0040_0010, 1, 1, 32'h0040_0008);
    vecs[5]  = mkv(1, 0, 0,            1, 32'h0040_0014, 1, 1, 32'h0040_000C);
    vecs[6]  = mkv(1, 0, 0,            1, 32'h0040_0018, 1, 1, 32'h0040_0010);
    vecs[7]  = mkv(1, 0, 0,            1, 32'h0040_001C, 1, 1, 32'h0040_0014);
    vecs[8]  = mkv(1, 1, 32'h0040_0200, 0, 0,            0, 1, 32'h0040_0018);
    vecs[9]  = mkv(1, 0, 0,            1, 32'h0040_0200, 1, 0, 0);
    vecs[10] = mkv(1, 0, 0,            1, 32'h0040_0204, 1, 0, 0);
    vecs[11] = mkv(1, 0, 0,            1, 32'h0040_0208, 1, 1, 32'h0040_0200);
    vecs[12] = mkv(1, 0, 0,            1, 32'h0040_020C, 1, 1, 32'h0040_0204);

    // Reset values
    resetDut();
    #2;
    checkOutput("rst_req",   imem_req,   0);
    checkOutput("rst_valid", inst_valid, 0);
    checkOutput("rst_inst",  inst,       0);
    checkOutput("rst_pc",    inst_pc,    0);
    checkOutput("rst_fault", inst_fault, 0);

    // Streaming from reset, then a redirect coinciding with a response and a pop
    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].ready, vecs[i].redir, vecs[i].rpc);
      checkOutput($sformatf("vec%0d_req", i), imem_req, vecs[i].exp_req);
      if (vecs[i].chk_addr) checkOutput($sformatf("vec%0d_addr", i), imem_addr, vecs[i].exp_addr);
      checkOutput($sformatf("vec%0d_valid", i), inst_valid, vecs[i].exp_valid);
      if (vecs[i].exp_valid) begin
        checkOutput($sformatf("vec%0d_pc", i), inst_pc, vecs[i].exp_pc);
        checkOutput($sformatf("vec%0d_inst", i), inst, vecs[i].exp_pc ^ KEY);
      end
    end

    // Backpressure: credit stops requests at DEPTH, then an in-order drain
    resetDut();
    grants = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 1'b0, '0);
      if (imem_req && imem_gnt) grants++;
    end
    checkOutput("bp_grants", grants, 4);
    checkOutput("bp_req_off", imem_req, 0);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 1'b0, '0);
      checkOutput($sformatf("drain%0d_valid", i), inst_valid, 1);
      checkOutput($sformatf("drain%0d_pc", i), inst_pc, 32'h0040_0000 + 32'(4 * i));
    end

    // Slow memory: two stale words in flight are dropped after a redirect
    resetDut();
    lat = 3;
    applyStimulus(1'b1, 1'b0, '0);
    applyStimulus(1'b1, 1'b0, '0);
    checkOutput("lat3_addr1", imem_addr, 32'h0040_0004);
    applyStimulus(1'b1, 1'b1, 32'h0040_0100);
    checkOutput("lat3_redir_req", imem_req, 0);
    waitValid("lat3_wait", 12, cyc);
    checkOutput("lat3_latency", cyc, 4);
    checkOutput("lat3_pc0", inst_pc, 32'h0040_0100);
    checkOutput("lat3_inst0", inst, 32'h0040_0100 ^ KEY);
    applyStimulus(1'b1, 1'b0, '0);
    checkOutput("lat3_valid1", inst_valid, 1);
    checkOutput("lat3_pc1", inst_pc, 32'h0040_0104);

    // Grant stall holds the request address steady
    resetDut();
    gnt_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b0, '0);
      checkOutput($sformatf("stall%0d_req", i), imem_req, 1);
      checkOutput($sformatf("stall%0d_addr", i), imem_addr, 32'h0040_0000);
    end
    applyStimulus(1'b1, 1'b0, '0);
    gnt_en = 1'b1;
    checkOutput("stall_gnt_addr", imem_addr, 32'h0040_0000);
    applyStimulus(1'b1, 1'b0, '0);
    checkOutput("stall_next_addr", imem_addr, 32'h0040_0004);
    waitValid("stall_wait", 8, cyc);
    checkOutput("stall_pc", inst_pc, 32'h0040_0000);

`ifdef FETCH_FAULT_EN
    // Misaligned redirect yields one fault entry and halts fetch
    resetDut();
    repeat (3) applyStimulus(1'b1, 1'b0, '0);
    applyStimulus(1'b0, 1'b1, 32'h0040_0102);
    applyStimulus(1'b0, 1'b0, '0);
    checkOutput("mis_req1", imem_req, 0);
    checkOutput("mis_valid1", inst_valid, 0);
    applyStimulus(1'b1, 1'b0, '0);
    checkOutput("mis_valid2", inst_valid, 1);
    checkOutput("mis_pc", inst_pc, 32'h0040_0102);
    checkOutput("mis_inst", inst, 0);
    checkOutput("mis_fault", inst_fault, 1);
    reqs = 0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b0, '0);
      if (imem_req) reqs++;
    end
    checkOutput("mis_halt_reqs", reqs, 0);
    checkOutput("mis_halt_valid", inst_valid, 0);
    err_addr = 32'h0040_0304;
    applyStimulus(1'b1, 1'b1, 32'h0040_0300);
    waitValid("err_wait", 8, cyc);
    checkOutput("err_pc0", inst_pc, 32'h0040_0300);
    checkOutput("err_fault0", inst_fault, 0);
    applyStimulus(1'b1, 1'b0, '0);
    checkOutput("err_pc1", inst_pc, 32'h0040_0304);
    checkOutput("err_fault1", inst_fault, 1);
`else
    // Without the fault path the low redirect bits are dropped
    resetDut();
    reqs = 0;
    applyStimulus(1'b1, 1'b1, 32'h0040_0206);
    applyStimulus(1'b1, 1'b0, '0);
    checkOutput("align_addr", imem_addr, 32'h0040_0204);
    waitValid("align_wait", 8, cyc);
    checkOutput("align_pc", inst_pc, 32'h0040_0204);
    checkOutput("align_fault", inst_fault, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
